// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//   Serial front end for the 4x4 matrix-vector multiplier. Collects a 20-element frame
//   (16 matrix elements in row-major order, then 4 vector words) from a valid/ready
//   stream and presents it as packed row buses A1..A4 and vector words X1..X4.
//
// Ports:
//   clk        system clock, rising edge
//   clear      synchronous active-high reset
//   in_data    element word (N bits)
//   in_valid   in_data valid this cycle
//   in_ready   loader accepts an element this cycle (LOAD state)
//   A1..A4     packed matrix rows, column 1 in the MSBs
//   X1..X4     vector words
//   mat_valid  complete operand set held on A/X (FULL state)
//   mat_ack    consumer has taken the operand set (only honoured in FULL)
//   elem_count elements accepted in the current frame, 0..20
module matrix_operand_loader #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           clear,
  input  logic [N-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [4*N-1:0] A1,
  output logic [4*N-1:0] A2,
  output logic [4*N-1:0] A3,
  output logic [4*N-1:0] A4,
  output logic [N-1:0]   X1,
  output logic [N-1:0]   X2,
  output logic [N-1:0]   X3,
  output logic [N-1:0]   X4,
  output logic           mat_valid,
  input  logic           mat_ack,
  output logic [4:0]     elem_count
);

  typedef enum logic [0:0] {StLoad, StFull} state_e;

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  // Matrix elements indexed by k = 4*row + col; vector words by k - 16.
  logic [N-1:0] a_q [16];
  logic [N-1:0] a_d [16];
  logic [N-1:0] x_q [4];
  logic [N-1:0] x_d [4];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    x_d       = x_q;
    // Handshake outputs come straight from the state register.
    in_ready  = (state_q == StLoad);
    mat_valid = (state_q == StFull);

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (cnt_q < 5'd16) begin
            a_d[cnt_q[3:0]] = in_data;
          end else begin
            x_d[cnt_q[1:0]] = in_data;
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd19) begin
            state_d = StFull;
          end
        end
      end
      StFull: begin
        // Registers are frozen here; stray in_valid is simply not consumed.
        if (mat_ack) begin
          state_d = StLoad;
          cnt_d   = 5'd0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= StLoad;
      cnt_q   <= 5'd0;
      a_q     <= '{default: '0};
      x_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      x_q     <= x_d;
    end
  end

  assign A1 = {a_q[0],  a_q[1],  a_q[2],  a_q[3]};
  assign A2 = {a_q[4],  a_q[5],  a_q[6],  a_q[7]};
  assign A3 = {a_q[8],  a_q[9],  a_q[10], a_q[11]};
  assign A4 = {a_q[12], a_q[13], a_q[14], a_q[15]};
  assign X1 = x_q[0];
  assign X2 = x_q[1];
  assign X3 = x_q[2];
  assign X4 = x_q[3];
  assign elem_count = cnt_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Self-checking bench for matrix_operand_loader (N = 4). Expected frames are pushed to a
// scoreboard queue when their stimulus is driven and popped when mat_valid is seen.
module tb_matrix_operand_loader;

  localparam int unsigned N = 4;

  logic           clk;
  logic           clear;
  logic [N-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [4*N-1:0] A1, A2, A3, A4;
  logic [N-1:0]   X1, X2, X3, X4;
  logic           mat_valid;
  logic           mat_ack;
  logic [4:0]     elem_count;

  matrix_operand_loader #(.N(N)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A1        (A1),
    .A2        (A2),
    .A3        (A3),
    .A4        (A4),
    .X1        (X1),
    .X2        (X2),
    .X3        (X3),
    .X4        (X4),
    .mat_valid (mat_valid),
    .mat_ack   (mat_ack),
    .elem_count(elem_count)
  );

  typedef struct packed {
    logic [63:0] a;  // {A1, A2, A3, A4}
    logic [15:0] x;  // {X1, X2, X3, X4}
  } frame_t;

  frame_t     sb_q[$];
  frame_t     exp_last;
  int         n_checks;
  int         n_errors;
  int         cyc;
  int         seen_cyc;
  int         prev_cyc;
  int         start_cyc;
  logic [3:0] v [20];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the 20 elements in v. Optional bubble cycles, a stray ack at element index
  // stray_at, or an ack cycle (with in_valid already high) before the first element.
  task automatic load_frame(input bit bubble, input int stray_at, input bit ack_first);
    frame_t e;
    e = '0;
    for (int k = 0; k < 20; k++) begin
      if (k < 16) e.a[63-4*k -: 4] = v[k];
      else        e.x[15-4*(k-16) -: 4] = v[k];
    end
    sb_q.push_back(e);
    if (ack_first) begin
      in_valid = 1'b1;
      in_data  = v[0];
      mat_ack  = 1'b1;
      step();
      mat_ack = 1'b0;
      chk("ack_drops_valid", {79'd0, mat_valid}, 80'd0);
      chk("ack_count_zero", {75'd0, elem_count}, 80'd0);
    end
    start_cyc = cyc;
    for (int k = 0; k < 20; k++) begin
      if (k == stray_at) begin
        in_valid = 1'b0;
        mat_ack  = 1'b1;
        step();
        mat_ack = 1'b0;
        chk("stray_ack_count", {75'd0, elem_count}, 80'(k));
        chk("stray_ack_ready", {79'd0, in_ready}, 80'd1);
      end
      in_valid = 1'b1;
      in_data  = v[k];
      step();
      if (k == 0 && ack_first) chk("b2b_first_accept", {75'd0, elem_count}, 80'd1);
      if (k == stray_at) chk("stray_next_count", {75'd0, elem_count}, 80'(k + 1));
      if (bubble && k < 19) begin
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !mat_valid; i++) step();
    chk("frame_timeout", {79'd0, mat_valid}, 80'd1);
    prev_cyc = seen_cyc;
    seen_cyc = cyc;
  endtask

  task automatic check_frame(input string tag);
    frame_t e;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      exp_last = e;
      chk({tag, "_A"}, {16'd0, A1, A2, A3, A4}, {16'd0, e.a});
      chk({tag, "_X"}, {64'd0, X1, X2, X3, X4}, {64'd0, e.x});
      chk({tag, "_count"}, {75'd0, elem_count}, 80'd20);
      chk({tag, "_ready"}, {79'd0, in_ready}, 80'd0);
    end
  endtask

  task automatic ack();
    mat_ack = 1'b1;
    step();
    mat_ack = 1'b0;
    chk("ack_valid_low", {79'd0, mat_valid}, 80'd0);
    chk("ack_ready_high", {79'd0, in_ready}, 80'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    seen_cyc = 0;
    prev_cyc = 0;
    clear    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    mat_ack  = 1'b0;
    step();
    step();
    clear = 1'b0;

    // Reset state
    chk("rst_outputs", {A1, A2, A3, A4, X1, X2, X3, X4}, 80'd0);
    chk("rst_count", {75'd0, elem_count}, 80'd0);
    chk("rst_hs", {78'd0, in_ready, mat_valid}, 80'b10);

    // Basic load
    for (int k = 0; k < 16; k++) v[k] = 4'(k % 4 + 1);
    for (int k = 16; k < 20; k++) v[k] = 4'd1;
    load_frame(1'b0, -1, 1'b0);
    wait_valid();
    chk("basic_latency", 80'(seen_cyc - start_cyc), 80'd20);
    check_frame("basic");
    chk("basic_A1", {64'd0, A1}, 80'h1234);

    // Backpressure and hold
    in_valid = 1'b1;
    in_data  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_outputs", {A1, A2, A3, A4, X1, X2, X3, X4}, {exp_last.a, exp_last.x});
      chk("hold_state", {73'd0, elem_count, in_ready, mat_valid}, {73'd0, 5'd20, 2'b01});
    end
    in_valid = 1'b0;
    ack();
    chk("post_ack_A1", {64'd0, A1}, 80'h1234);

    // Bubbles
    for (int k = 0; k < 16; k++) v[k] = 4'(k);
    for (int k = 16; k < 20; k++) v[k] = 4'(k - 11);
    load_frame(1'b1, -1, 1'b0);
    wait_valid();
    chk("bubble_latency", 80'(seen_cyc - start_cyc), 80'd39);
    check_frame("bubble");
    ack();

    // Reset mid-frame; clear also overrides a concurrent accept
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k + 9);
      step();
    end
    chk("partial_count", {75'd0, elem_count}, 80'd7);
    clear = 1'b1;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("midrst_outputs", {A1, A2, A3, A4, X1, X2, X3, X4}, 80'd0);
    chk("midrst_count", {75'd0, elem_count}, 80'd0);
    for (int k = 0; k < 20; k++) v[k] = 4'($urandom);
    load_frame(1'b0, -1, 1'b0);
    wait_valid();
    check_frame("after_rst");
    ack();

    // Stray ack at elem_count = 10
    for (int k = 0; k < 20; k++) v[k] = 4'(19 - k);
    load_frame(1'b0, 10, 1'b0);
    wait_valid();
    check_frame("stray");
    ack();

    // Back-to-back frames
    for (int k = 0; k < 20; k++) v[k] = 4'($urandom);
    load_frame(1'b0, -1, 1'b0);
    wait_valid();
    check_frame("b2b_first");
    for (int k = 0; k < 20; k++) v[k] = 4'($urandom);
    load_frame(1'b0, -1, 1'b1);
    wait_valid();
    chk("b2b_period", 80'(seen_cyc - prev_cyc), 80'd21);
    check_frame("b2b_second");

    // Reset in FULL drops mat_valid without an ack
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("full_rst_hs", {78'd0, in_ready, mat_valid}, 80'b10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
